// File: rtl/pipe_pkg.sv
// Shared definitions for the fetch/decode pipeline boundary: NOP encoding,
// the fetch beat layout and the occupancy encodings of the IF/ID skid stage.
package pipe_pkg;

   localparam int unsigned PIPE_XLEN = 32;
   localparam int unsigned PIPE_ILEN = 32;
   localparam logic [31:0] RV_NOP    = 32'h0000_0013;

   typedef struct packed {
      logic [PIPE_XLEN-1:0] pc;
      logic [PIPE_ILEN-1:0] inst;
   } fetch_beat_t;

   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_FULL  = 2'd2,
      OCC_BAD   = 2'd3
   } occ_e;

   // The skid slot is only ever filled behind a valid main slot, so {0,1} is unreachable.
   function automatic occ_e occ_of(input logic main_v, input logic skid_v);
      occ_e occ;
      case ({main_v, skid_v})
         2'b00:   occ = OCC_EMPTY;
         2'b10:   occ = OCC_ONE;
         2'b11:   occ = OCC_FULL;
         default: occ = OCC_BAD;
      endcase
      return occ;
   endfunction

endpackage

// File: rtl/skid_slot.sv
// One valid+payload holding register; clear takes priority over load.
module skid_slot #(
   parameter int unsigned W = 64
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load_i,
   input  logic         clear_i,
   input  logic [W-1:0] data_i,
   output logic         valid_o,
   output logic [W-1:0] data_o
);

   logic         valid_q;
   logic [W-1:0] data_q;

   // Valid flag and payload storage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else if (clear_i) begin
         valid_q <= 1'b0;
      end else if (load_i) begin
         valid_q <= 1'b1;
         data_q  <= data_i;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;

endmodule

// File: rtl/if_id_skid.sv
// IF->ID elastic stage: main register feeds decode, a skid register absorbs one
// extra beat so in_ready is purely registered. Flush squashes and counts beats.
module if_id_skid
   import pipe_pkg::*;
#(
   parameter int unsigned     XLEN     = 32,
   parameter int unsigned     ILEN     = 32,
   parameter logic [ILEN-1:0] NOP_INST = ILEN'(RV_NOP),
   parameter int unsigned     CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [XLEN-1:0]  in_pc,
   input  logic [ILEN-1:0]  in_inst,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_pc,
   output logic [ILEN-1:0]  out_inst,
   output logic [1:0]       occupancy,
   output logic [CNT_W-1:0] drop_cnt
);

   localparam int unsigned W = XLEN + ILEN;

   logic             main_valid_s, skid_valid_s;
   logic [W-1:0]     main_data_s, skid_data_s, in_data_s, main_load_data_s;
   logic             main_load_s, main_clear_s, skid_load_s, skid_clear_s;
   logic             in_xfer_s, out_xfer_s;
   occ_e             occ_s;
   logic [1:0]       drop_add_s;
   logic [CNT_W+1:0] cnt_sum_s;
   logic [CNT_W-1:0] drop_cnt_d, drop_cnt_q;

   assign in_data_s  = {in_pc, in_inst};
   assign occ_s      = occ_of(main_valid_s, skid_valid_s);
   assign in_ready   = ~skid_valid_s;
   assign in_xfer_s  = in_valid & ~skid_valid_s;
   assign out_xfer_s = main_valid_s & out_ready;

   // Slot load/clear decisions derived from occupancy and both handshakes.
   always_comb begin
      main_load_s      = 1'b0;
      main_clear_s     = 1'b0;
      skid_load_s      = 1'b0;
      skid_clear_s     = 1'b0;
      main_load_data_s = in_data_s;
      if (flush) begin
         main_clear_s = 1'b1;
         skid_clear_s = 1'b1;
      end else begin
         case (occ_s)
            OCC_EMPTY: begin
               main_load_s = in_xfer_s;
            end
            OCC_ONE: begin
               if (in_xfer_s && out_xfer_s) begin
                  main_load_s = 1'b1;
               end else if (in_xfer_s) begin
                  skid_load_s = 1'b1;
               end else if (out_xfer_s) begin
                  main_clear_s = 1'b1;
               end else begin
                  main_load_s = 1'b0;
               end
            end
            OCC_FULL: begin
               if (out_xfer_s) begin
                  main_load_s      = 1'b1;
                  main_load_data_s = skid_data_s;
                  skid_clear_s     = 1'b1;
               end else begin
                  main_load_s = 1'b0;
               end
            end
            default: begin
               main_clear_s = 1'b1;
               skid_clear_s = 1'b1;
            end
         endcase
      end
   end

   skid_slot #(.W(W)) u_main (
      .clk     (clk),
      .rst_n   (rst_n),
      .load_i  (main_load_s),
      .clear_i (main_clear_s),
      .data_i  (main_load_data_s),
      .valid_o (main_valid_s),
      .data_o  (main_data_s)
   );

   skid_slot #(.W(W)) u_skid (
      .clk     (clk),
      .rst_n   (rst_n),
      .load_i  (skid_load_s),
      .clear_i (skid_clear_s),
      .data_i  (in_data_s),
      .valid_o (skid_valid_s),
      .data_o  (skid_data_s)
   );

   // A main beat leaving to decode in the flush cycle is consumed, not dropped.
   always_comb begin
      drop_add_s = {1'b0, main_valid_s & ~out_ready} + {1'b0, skid_valid_s} + {1'b0, in_xfer_s};
      cnt_sum_s  = {2'b00, drop_cnt_q} + {{CNT_W{1'b0}}, drop_add_s};
      if (!flush) begin
         drop_cnt_d = drop_cnt_q;
      end else if (cnt_sum_s[CNT_W+1:CNT_W] != 2'b00) begin
         drop_cnt_d = {CNT_W{1'b1}};
      end else begin
         drop_cnt_d = cnt_sum_s[CNT_W-1:0];
      end
   end

   // Saturating flush-drop counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drop_cnt_q <= '0;
      end else begin
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign out_valid = main_valid_s;
   assign out_pc    = main_valid_s ? main_data_s[W-1:ILEN] : '0;
   assign out_inst  = main_valid_s ? main_data_s[ILEN-1:0] : NOP_INST;
   assign occupancy = 2'(occ_s);
   assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_if_id_skid.sv
// Directed bench for if_id_skid; a second instance with a 2-bit counter shares
// the stimulus so saturation is observed alongside the normal counter.
module tb_if_id_skid;

   logic        clk;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready, in_ready2;
   logic [31:0] in_pc;
   logic [31:0] in_inst;
   logic        out_valid, out_valid2;
   logic        out_ready;
   logic [31:0] out_pc, out_pc2;
   logic [31:0] out_inst, out_inst2;
   logic [1:0]  occupancy, occupancy2;
   logic [15:0] drop_cnt;
   logic [1:0]  drop_cnt2;

   int tests;
   int fails;

   if_id_skid dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_pc     (in_pc),
      .in_inst   (in_inst),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_pc    (out_pc),
      .out_inst  (out_inst),
      .occupancy (occupancy),
      .drop_cnt  (drop_cnt)
   );

   if_id_skid #(.CNT_W(2)) dut_sat (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready2),
      .in_pc     (in_pc),
      .in_inst   (in_inst),
      .out_valid (out_valid2),
      .out_ready (out_ready),
      .out_pc    (out_pc2),
      .out_inst  (out_inst2),
      .occupancy (occupancy2),
      .drop_cnt  (drop_cnt2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                        input logic rdy, input logic fl);
      in_valid  = v;
      in_pc     = pc;
      in_inst   = inst;
      out_ready = rdy;
      flush     = fl;
   endtask

   initial begin
      tests = 0;
      fails = 0;
      rst_n = 1'b0;
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      #2;
      check("rst_out_valid", {63'd0, out_valid}, 64'd0);
      check("rst_in_ready",  {63'd0, in_ready},  64'd1);
      check("rst_out_pc",    {32'd0, out_pc},    64'd0);
      check("rst_out_inst",  {32'd0, out_inst},  64'h13);
      check("rst_occ",       {62'd0, occupancy}, 64'd0);
      check("rst_drop",      {48'd0, drop_cnt},  64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Streaming at full rate
      drive(1'b1, 32'h0, 32'hA0, 1'b1, 1'b0);
      step();
      check("s0_pc",   {32'd0, out_pc},    64'h0);
      check("s0_inst", {32'd0, out_inst},  64'hA0);
      check("s0_vld",  {63'd0, out_valid}, 64'd1);
      drive(1'b1, 32'h4, 32'hA1, 1'b1, 1'b0);
      step();
      check("s1_pc",   {32'd0, out_pc},    64'h4);
      check("s1_occ",  {62'd0, occupancy}, 64'd1);
      check("s1_rdy",  {63'd0, in_ready},  64'd1);
      drive(1'b1, 32'h8, 32'hA2, 1'b1, 1'b0);
      step();
      check("s2_pc",   {32'd0, out_pc},    64'h8);
      check("s2_inst", {32'd0, out_inst},  64'hA2);
      check("s2_occ",  {62'd0, occupancy}, 64'd1);
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      step();
      check("drain_vld",  {63'd0, out_valid}, 64'd0);
      check("drain_pc",   {32'd0, out_pc},    64'd0);
      check("drain_inst", {32'd0, out_inst},  64'h13);

      // Back-pressure fills the skid, then drains in order
      drive(1'b1, 32'h10, 32'hB0, 1'b0, 1'b0);
      step();
      check("bp0_occ", {62'd0, occupancy}, 64'd1);
      drive(1'b1, 32'h14, 32'hB1, 1'b0, 1'b0);
      step();
      check("bp1_occ", {62'd0, occupancy}, 64'd2);
      check("bp1_rdy", {63'd0, in_ready},  64'd0);
      check("bp1_pc",  {32'd0, out_pc},    64'h10);
      check("bp1_inst",{32'd0, out_inst},  64'hB0);
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      step();
      check("bp_hold_pc",  {32'd0, out_pc},    64'h10);
      check("bp_hold_occ", {62'd0, occupancy}, 64'd2);
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      step();
      check("bp2_pc",   {32'd0, out_pc},    64'h14);
      check("bp2_inst", {32'd0, out_inst},  64'hB1);
      check("bp2_occ",  {62'd0, occupancy}, 64'd1);
      check("bp2_rdy",  {63'd0, in_ready},  64'd1);
      step();
      check("bp3_vld", {63'd0, out_valid}, 64'd0);
      check("bp3_occ", {62'd0, occupancy}, 64'd0);

      // Flush while FULL with a stalled incoming beat
      drive(1'b1, 32'h20, 32'hC0, 1'b0, 1'b0);
      step();
      drive(1'b1, 32'h24, 32'hC1, 1'b0, 1'b0);
      step();
      check("ff_pre_occ", {62'd0, occupancy}, 64'd2);
      drive(1'b1, 32'h28, 32'hC2, 1'b0, 1'b1);
      step();
      check("ff_vld",   {63'd0, out_valid}, 64'd0);
      check("ff_inst",  {32'd0, out_inst},  64'h13);
      check("ff_pc",    {32'd0, out_pc},    64'd0);
      check("ff_occ",   {62'd0, occupancy}, 64'd0);
      check("ff_drop",  {48'd0, drop_cnt},  64'd2);
      check("ff_drop2", {62'd0, drop_cnt2}, 64'd2);

      // Flush while ONE: main beat consumed, incoming beat dropped
      drive(1'b1, 32'h30, 32'hD0, 1'b0, 1'b0);
      step();
      check("f1_pre_occ", {62'd0, occupancy}, 64'd1);
      drive(1'b1, 32'h34, 32'hD1, 1'b1, 1'b1);
      step();
      check("f1_occ",   {62'd0, occupancy}, 64'd0);
      check("f1_drop",  {48'd0, drop_cnt},  64'd3);
      check("f1_drop2", {62'd0, drop_cnt2}, 64'd3);

      // Further flushes: wide counter keeps adding, narrow one holds at 3
      drive(1'b1, 32'h38, 32'hE0, 1'b0, 1'b0);
      step();
      drive(1'b1, 32'h3C, 32'hE1, 1'b0, 1'b0);
      step();
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
      step();
      check("sat_drop",  {48'd0, drop_cnt},  64'd5);
      check("sat_drop2", {62'd0, drop_cnt2}, 64'd3);
      drive(1'b1, 32'h40, 32'hE2, 1'b0, 1'b1);
      step();
      check("sat2_drop",  {48'd0, drop_cnt},  64'd6);
      check("sat2_drop2", {62'd0, drop_cnt2}, 64'd3);
      check("sat2_occ",   {62'd0, occupancy}, 64'd0);

      // Asynchronous reset while FULL
      drive(1'b1, 32'h44, 32'hF0, 1'b0, 1'b0);
      step();
      drive(1'b1, 32'h48, 32'hF1, 1'b0, 1'b0);
      step();
      check("ar_pre_occ", {62'd0, occupancy}, 64'd2);
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      rst_n = 1'b0;
      #1;
      check("ar_vld",   {63'd0, out_valid}, 64'd0);
      check("ar_rdy",   {63'd0, in_ready},  64'd1);
      check("ar_occ",   {62'd0, occupancy}, 64'd0);
      check("ar_drop",  {48'd0, drop_cnt},  64'd0);
      check("ar_drop2", {62'd0, drop_cnt2}, 64'd0);
      check("ar_inst",  {32'd0, out_inst},  64'h13);
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b1, 32'h50, 32'h0C0, 1'b1, 1'b0);
      step();
      check("rr_pc",   {32'd0, out_pc},    64'h50);
      check("rr_inst", {32'd0, out_inst},  64'hC0);
      check("rr_occ",  {62'd0, occupancy}, 64'd1);
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      step();
      check("rr_end_occ", {62'd0, occupancy}, 64'd0);
      check("rr_end_drop", {48'd0, drop_cnt}, 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/if_id_skid.md
Name: if_id_skid

Overview:
- Parametrised IF→ID boundary register: next generation of the fetch/decode stage register.
- Replaces the plain stall/jump register with a valid/ready elastic stage backed by a 2-entry skid buffer.
- Accepts fetched {pc, inst} beats from fetch and presents them to decode.
- Squashes in-flight beats on redirect (flush) and counts the beats it squashes.
- Sits between the fetch unit and the decoder; ready can be a registered signal, so the stall path no longer combinationally crosses the stage.

Parameters:
- XLEN, 32, width of the instruction-address field.
- ILEN, 32, width of the instruction field.
- NOP_INST, 32'h0000_0013, value driven on out_inst when out_valid=0 (addi x0,x0,0).
- CNT_W, 16, width of the saturating flush-drop counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  redirect/jump: squash all held beats and any beat presented this cycle.
- in_valid  in  1  fetch presents a beat.
- in_ready  out  1  stage can accept a beat; registered, equals !skid_valid.
- in_pc  in  XLEN  instruction address of the incoming beat.
- in_inst  in  ILEN  instruction word of the incoming beat.
- out_valid  out  1  main register holds a valid beat.
- out_ready  in  1  decode accepts the beat (0 = decode stall).
- out_pc  out  XLEN  address of the held beat; 0 when out_valid=0.
- out_inst  out  ILEN  held instruction; NOP_INST when out_valid=0.
- occupancy  out  2  number of held beats: 0, 1 or 2.
- drop_cnt  out  CNT_W  saturating count of valid beats discarded by flush.

Behaviour:
- Storage: main register {main_valid, main_pc, main_inst} drives the outputs; skid register {skid_valid, skid_pc, skid_inst} holds overflow.
- Reset, asynchronous: main_valid=0 and skid_valid=0 immediately; in_ready=1; out_valid=0; out_pc=0; out_inst=NOP_INST; occupancy=0; drop_cnt=0.
- Handshakes:
  - Input transfer: in_valid & in_ready at a rising edge.
  - Output transfer: out_valid & out_ready at a rising edge.
  - Data must not change while in_valid=1 and in_ready=0. The stage does not check this.
- State is implied by occupancy: EMPTY(0), ONE(1), FULL(2).
- EMPTY:
  - Input transfer: load main → ONE.
  - Otherwise: stay EMPTY.
- ONE:
  - Input transfer and output transfer together: load main with the new beat → ONE.
  - Input transfer only: load skid → FULL.
  - Output transfer only: → EMPTY.
  - Neither: hold.
- FULL (in_ready=0):
  - Output transfer: skid moves to main, skid_valid clears → ONE.
  - No output transfer: hold all contents.
- Latency and throughput:
  - One cycle from input transfer to out_valid.
  - Full throughput of one beat per cycle when out_ready is held at 1.
- Beat order is strict FIFO. No beat is ever duplicated or lost, except by flush.
- Flush (synchronous, highest priority after reset):
  - At the edge, main_valid=0 and skid_valid=0 → EMPTY.
  - Any input beat presented that cycle is discarded, even if in_ready=1.
  - An output transfer in the flush cycle still counts as consumed by decode.
- drop_cnt:
  - On a flush edge, add the number of valid beats squashed: (main_valid & !out_ready) + skid_valid + (in_valid & in_ready).
  - Saturates at 2^CNT_W-1; never wraps.
- Output masking: out_pc and out_inst are forced to 0 / NOP_INST whenever out_valid=0. Decode therefore sees a bubble, never a stale or X value.
- Reset asserted mid-operation: all contents lost, outputs take reset values within the same cycle, drop_cnt is not incremented.
- in_ready depends only on state, with no combinational path from out_ready.

Decomposition:
- Shared package pipe_pkg holds:
  - the NOP_INST constant (RV_NOP);
  - typedef fetch_beat_t {pc, inst} with widths from XLEN/ILEN;
  - occupancy encodings OCC_EMPTY, OCC_ONE, OCC_FULL.
- One natural sub-module: skid_slot, a single valid+payload register with load/clear controls, instanced twice (main and skid).
- Next-state and counter logic stay in if_id_skid.

Test Plan:
- Reset then stream: in_valid=1 with pc 0x0,0x4,0x8 and out_ready=1 → out_pc 0x0,0x4,0x8 on consecutive cycles, occupancy stays 1, in_ready stays 1.
- Back-pressure: out_ready=0 while sending pc 0x10 then 0x14 → occupancy=2, in_ready=0, out_pc holds 0x10. Raise out_ready → 0x10 then 0x14 delivered in order, no loss.
- Flush when FULL with out_ready=0, plus in_valid=1 and in_ready=0 → next cycle out_valid=0, out_inst=0x00000013, out_pc=0, occupancy=0, drop_cnt=2.
- Flush when ONE with in_valid=1, out_ready=1 → the main beat is consumed and not counted; the incoming beat is dropped; drop_cnt+1; EMPTY.
- Saturation with CNT_W=2: repeated FULL flushes → drop_cnt reaches 3 and holds at 3.
- Assert rst_n=0 mid-stream while FULL → out_valid=0 and in_ready=1 without a clock edge, drop_cnt=0; traffic resumes correctly after release.
